serial_demux_ctrl_n: RTL
========================

Name: serial_demux_ctrl_n

Overview:
Parametrised successor to the lab's 4-port serial demultiplexer (controller plus datapath). It parses a framed serial stream: start bit, port number, length field, then that many payload bits. Payload is routed to one of NUM_PORTS outputs. Relative to the fixed 4-port design it adds:
- generic port count and length width;
- an optional parity check;
- a busy flag;
- explicit zero-length handling.

It sits behind the push-button one-pulser and drives the port pins and the seven-segment count decoder.

Parameters:
NUM_PORTS, 4, number of output ports; must be a power of two, at least 2.
PORT_W, 2, port field width; must equal log2(NUM_PORTS).
CNT_W, 4, length field width; maximum payload is 2^CNT_W-1 bits.
PARITY_EN, 0, 1 = a trailing even-parity bit follows the payload.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
clk_en  in  1  bit strobe, one clk cycle wide (from the one-pulser); ser_in is consumed only when clk_en=1.
ser_in  in  1  serial input; idle level 1.
port_out  out  NUM_PORTS  port_out[port_num]=ser_in while in DATA; all other bits 0; all bits 0 outside DATA.
port_num  out  PORT_W  registered captured port field.
rem_cnt  out  CNT_W  registered count of payload bits still to be received; feeds the SSD.
ser_out_valid  out  1  1 while state=DATA.
busy  out  1  1 in any state except IDLE.
done  out  1  one-clk pulse at frame end.
parity_err  out  1  registered, sticky until the next start bit; always 0 when PARITY_EN=0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; port_num=0, rem_cnt=0, done=0, parity_err=0, shift registers and bit counter=0. Reset mid-frame aborts the frame immediately. No done pulse is issued for the aborted frame.
- All state changes and register updates happen on a rising clk edge where clk_en=1. The only exceptions are reset and the DONE→IDLE exit.
- IDLE: ser_in=0 is the start bit → PORT. On entry to PORT: parity_err cleared, bit counter cleared. ser_in=1 stays in IDLE.
- PORT: shift PORT_W bits MSB-first into port_num; after the PORT_W-th bit → LEN.
- LEN: shift CNT_W bits MSB-first into rem_cnt; after the CNT_W-th bit:
  - length nonzero → DATA;
  - length 0 → PAR if PARITY_EN, else DONE.
- DATA: each strobe consumes one payload bit and decrements rem_cnt. On the strobe where rem_cnt goes 1→0 → PAR if PARITY_EN, else DONE. rem_cnt never wraps below 0.
- PAR: one strobe samples the parity bit → DONE.
  - parity_err = XOR of all port, length, payload and parity bits (the sum must be even, so an odd total sets the flag).
  - The flag is visible from the cycle after the sample.
- DONE: done=1 for exactly one clk cycle, regardless of clk_en, then → IDLE. A start bit arriving on that same edge is ignored; the next frame may start from the following strobe.
- port_out is combinational from ser_in and the registered port_num/state; there is no added latency. A routed bit is valid on the cycle its clk_en is high.
- ser_in is ignored on cycles with clk_en=0 in every state. Arbitrary gaps between strobes are legal.
- port_num and rem_cnt hold their values after DONE until the next frame's PORT/LEN shifts overwrite them.

Test Plan:
- Defaults, frame bits 0,10,0011,101 → port_num=2, rem_cnt 3→2→1→0; port_out[2] follows 1,0,1 with ser_out_valid=1 for 3 strobes; port_out[0,1,3]=0; single done pulse.
- Zero length: 0,01,0000 → no DATA state, ser_out_valid never 1, done one cycle after the 4th length bit's edge, busy deasserts.
- PARITY_EN=1, frame 0,11,0010,10 with parity bit 1 → parity_err=1 (total odd). Same frame with parity bit 0 → parity_err=0.
- Reset asserted after the 2nd payload bit of a length-5 frame → all outputs 0 immediately and no done. A fresh frame afterwards is parsed correctly.
- clk_en strobes with random gaps of 0–7 cycles through a length-15 frame → identical results to back-to-back strobes, rem_cnt reaches 0 without wrap.
- NUM_PORTS=8, PORT_W=3: port field 111 → only port_out[7] carries the data.

Source files
------------

// File: rtl/serial_demux_ctrl_n_if.sv
// Bus bundle for the serial demultiplexer: bit strobe and serial data in,
// routed port pins plus frame status out. The master side drives the stream,
// the slave side is the demultiplexer itself.
interface serial_demux_ctrl_n_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int CNT_W     = 4
);
  logic                 clk_en;
  logic                 ser_in;
  logic [NUM_PORTS-1:0] port_out;
  logic [PORT_W-1:0]    port_num;
  logic [CNT_W-1:0]     rem_cnt;
  logic                 ser_out_valid;
  logic                 busy;
  logic                 done;
  logic                 parity_err;

  modport master (
    output clk_en, ser_in,
    input  port_out, port_num, rem_cnt, ser_out_valid, busy, done, parity_err
  );

  modport slave (
    input  clk_en, ser_in,
    output port_out, port_num, rem_cnt, ser_out_valid, busy, done, parity_err
  );
endinterface

// File: rtl/serial_demux_ctrl_n.sv
// Framed serial demultiplexer: start bit, MSB-first port field, MSB-first
// length field, payload bits, optional trailing even-parity bit. Payload bits
// are routed combinationally to the selected port pin while in DATA.
module serial_demux_ctrl_n #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int CNT_W     = 4,
  parameter int PARITY_EN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_demux_ctrl_n_if.slave  bus
);

  // Bit counter must cover whichever header field is wider.
  localparam int BW = (PORT_W > CNT_W) ? PORT_W : CNT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PORT,
    S_LEN,
    S_DATA,
    S_PAR,
    S_DONE
  } state_t;

  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [PORT_W-1:0] port_num_r;
  logic [CNT_W-1:0]  rem_cnt_r;
  logic              par_acc;
  logic              parity_err_r;
  logic              done_r;
  logic              busy_r;
  logic              vld_r;

  logic [PORT_W-1:0] port_next;
  logic [CNT_W-1:0]  len_next;

  // MSB-first shift: oldest bit ends up in the top position after the last bit.
  assign port_next = PORT_W'({port_num_r, bus.ser_in});
  assign len_next  = CNT_W'({rem_cnt_r, bus.ser_in});

  // Frame controller; every transition waits for a bit strobe except the
  // one-cycle DONE pulse, which always falls back to IDLE on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      port_num_r   <= '0;
      rem_cnt_r    <= '0;
      par_acc      <= 1'b0;
      parity_err_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      vld_r        <= 1'b0;
    end else if (state == S_DONE) begin
      state  <= S_IDLE;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else if (bus.clk_en) begin
      unique case (state)
        S_IDLE: begin
          if (!bus.ser_in) begin
            state        <= S_PORT;
            busy_r       <= 1'b1;
            bit_cnt      <= '0;
            par_acc      <= 1'b0;
            parity_err_r <= 1'b0;
          end
        end
        S_PORT: begin
          port_num_r <= port_next;
          par_acc    <= par_acc ^ bus.ser_in;
          if (bit_cnt == BW'(PORT_W - 1)) begin
            bit_cnt <= '0;
            state   <= S_LEN;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_LEN: begin
          rem_cnt_r <= len_next;
          par_acc   <= par_acc ^ bus.ser_in;
          if (bit_cnt == BW'(CNT_W - 1)) begin
            bit_cnt <= '0;
            if (len_next != '0) begin
              state <= S_DATA;
              vld_r <= 1'b1;
            end else if (PARITY_EN != 0) begin
              state <= S_PAR;
            end else begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          par_acc <= par_acc ^ bus.ser_in;
          // Saturating decrement: the count never wraps past zero.
          if (rem_cnt_r != '0) begin
            rem_cnt_r <= rem_cnt_r - 1'b1;
          end
          if (rem_cnt_r <= CNT_W'(1)) begin
            vld_r <= 1'b0;
            if (PARITY_EN != 0) begin
              state <= S_PAR;
            end else begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end
          end
        end
        S_PAR: begin
          // Even parity over header, payload and parity bit: odd total flags.
          parity_err_r <= (PARITY_EN != 0) & (par_acc ^ bus.ser_in);
          state        <= S_DONE;
          done_r       <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Payload routing: only the selected pin follows ser_in, and only in DATA.
  always_comb begin
    bus.port_out = '0;
    if (state == S_DATA) begin
      bus.port_out[port_num_r] = bus.ser_in;
    end
  end

  assign bus.port_num      = port_num_r;
  assign bus.rem_cnt       = rem_cnt_r;
  assign bus.ser_out_valid = vld_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.parity_err    = parity_err_r;

endmodule
